// File: rtl/alu_exec_seq.sv
// alu_exec_seq: EX-stage ALU with ALU-control decode, registered valid/ready
// handshake, a shift-add multiplier (mult/multu) and HI/LO registers.
module alu_exec_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inValid,
    input  logic [1:0]         aluOp,
    input  logic [FUNCT_W-1:0] fun,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               outValid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [3:0]         aluctrl,
    output logic               err,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [FUNCT_W-1:0] FunLowMask = FUNCT_W'(6'h3f);

    localparam logic [3:0] CtrlAnd   = 4'b0000;
    localparam logic [3:0] CtrlOr    = 4'b0001;
    localparam logic [3:0] CtrlAdd   = 4'b0010;
    localparam logic [3:0] CtrlSub   = 4'b0110;
    localparam logic [3:0] CtrlSlt   = 4'b0111;
    localparam logic [3:0] CtrlMult  = 4'b1000;
    localparam logic [3:0] CtrlMultu = 4'b1001;
    localparam logic [3:0] CtrlMfhi  = 4'b1010;
    localparam logic [3:0] CtrlMflo  = 4'b1011;
    localparam logic [3:0] CtrlNor   = 4'b1100;
    localparam logic [3:0] CtrlInv   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StFin  = 2'b10
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CntW-1:0]      cnt_q;
    logic                 sign_q;
    logic [3:0]           mulctrl_q;

    logic [3:0]           ctrl;
    logic [WIDTH-1:0]     exec_res;
    logic                 is_mul;
    logic                 fun_ok;
    logic [5:0]           fun6;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   prod;

    assign fun_ok = (fun & ~FunLowMask) == '0;
    assign fun6   = fun[5:0];

    // Decode aluOp/funct into the 4-bit ALU control code.
    always_comb begin
        ctrl = CtrlInv;
        case (aluOp)
            2'b00: ctrl = CtrlAdd;
            2'b01: ctrl = CtrlSub;
            2'b10: begin
                if (fun_ok) begin
                    case (fun6)
                        6'h20:   ctrl = CtrlAdd;
                        6'h22:   ctrl = CtrlSub;
                        6'h24:   ctrl = CtrlAnd;
                        6'h25:   ctrl = CtrlOr;
                        6'h2A:   ctrl = CtrlSlt;
                        6'h27:   ctrl = CtrlNor;
                        6'h18:   ctrl = CtrlMult;
                        6'h19:   ctrl = CtrlMultu;
                        6'h10:   ctrl = CtrlMfhi;
                        6'h12:   ctrl = CtrlMflo;
                        default: ctrl = CtrlInv;
                    endcase
                end
            end
            default: ctrl = CtrlInv;
        endcase
    end

    // Single-cycle datapath; invalid and multiply codes yield zero here.
    always_comb begin
        exec_res = '0;
        case (ctrl)
            CtrlAdd:  exec_res = a + b;
            CtrlSub:  exec_res = a - b;
            CtrlAnd:  exec_res = a & b;
            CtrlOr:   exec_res = a | b;
            CtrlSlt:  exec_res[0] = $signed(a) < $signed(b);
            CtrlNor:  exec_res = ~(a | b);
            CtrlMfhi: exec_res = hi_q;
            CtrlMflo: exec_res = lo_q;
            default:  exec_res = '0;
        endcase
    end

    assign is_mul = (ctrl == CtrlMult) || (ctrl == CtrlMultu);
    // Only signed mult takes magnitudes; the most negative value maps onto itself,
    // which read as unsigned is the correct magnitude.
    assign mag_a  = (ctrl == CtrlMult && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (ctrl == CtrlMult && b[WIDTH-1]) ? -b : b;
    assign prod   = sign_q ? -acc_q : acc_q;

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ready     <= 1'b1;
            busy      <= 1'b0;
            outValid  <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            aluctrl   <= 4'b0000;
            err       <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            mulctrl_q <= 4'b0000;
        end else begin
            outValid <= 1'b0;
            err      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (inValid && ready) begin
                        if (is_mul) begin
                            state_q   <= StMul;
                            ready     <= 1'b0;
                            busy      <= 1'b1;
                            acc_q     <= '0;
                            mcand_q   <= {{WIDTH{1'b0}}, mag_a};
                            mplier_q  <= mag_b;
                            cnt_q     <= CntW'(WIDTH);
                            sign_q    <= (ctrl == CtrlMult) & (a[WIDTH-1] ^ b[WIDTH-1]);
                            mulctrl_q <= ctrl;
                        end else begin
                            outValid <= 1'b1;
                            result   <= exec_res;
                            zero     <= (exec_res == '0);
                            aluctrl  <= ctrl;
                            err      <= (ctrl == CtrlInv);
                        end
                    end
                end
                StMul: begin
                    // One shift-add step per cycle; the cycle after the last step
                    // hands over to FIN.
                    if (cnt_q != '0) begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CntW'(1);
                    end else begin
                        state_q <= StFin;
                        busy    <= 1'b0;
                    end
                end
                StFin: begin
                    hi_q     <= prod[2*WIDTH-1:WIDTH];
                    lo_q     <= prod[WIDTH-1:0];
                    result   <= prod[WIDTH-1:0];
                    zero     <= (prod[WIDTH-1:0] == '0);
                    aluctrl  <= mulctrl_q;
                    outValid <= 1'b1;
                    ready    <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: stimulus pushes expectations, a monitor
// pops and compares on every outValid.
module tb_alu_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic [1:0]  aluOp = 2'b00;
    logic [5:0]  fun = 6'h00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, outValid, zero, err, busy;
    logic [31:0] result;
    logic [3:0]  aluctrl;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [3:0]  ctrl;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_exec_seq #(.WIDTH(32), .FUNCT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .aluOp    (aluOp),
        .fun      (fun),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .outValid (outValid),
        .result   (result),
        .zero     (zero),
        .aluctrl  (aluctrl),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Drive one request for one cycle; optionally record the expected response.
    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic push, input logic [31:0] er,
                         input logic [3:0] ec, input logic ee);
        exp_t e;
        @(negedge clk);
        inValid = 1'b1;
        aluOp   = op;
        fun     = f;
        a       = av;
        b       = bv;
        if (push) begin
            e.res  = er;
            e.zero = (er == 32'd0);
            e.ctrl = ec;
            e.err  = ee;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every outValid must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && outValid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_outvalid: got res=%h ctrl=%b err=%b expected none",
                             result, aluctrl, err);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res || zero !== e.zero || aluctrl !== e.ctrl ||
                        err !== e.err) begin
                        errors++;
                        $display("FAIL response: got res=%h zero=%b ctrl=%b err=%b expected res=%h zero=%b ctrl=%b err=%b",
                                 result, zero, aluctrl, err, e.res, e.zero, e.ctrl, e.err);
                    end
                end
            end
        end
    end

    // Multiply with latency and busy-length measurement plus ignored requests.
    task automatic run_mult(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] lo_exp, input logic [3:0] ec);
        int lat;
        int busy_cnt;
        issue(2'b10, f, av, bv, 1'b1, lo_exp, ec, 1'b0);
        @(posedge clk);
        #1;
        check("mul_ready_low", {63'd0, ready}, 64'd0);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        // Hold a request during busy; it must be dropped.
        aluOp = 2'b10;
        fun   = 6'h20;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) inValid = 1'b0;
            if (busy) busy_cnt++;
            if (outValid) begin
                lat = k;
                break;
            end
        end
        check("mul_latency", 64'(lat), 64'd34);
        check("mul_busy_cycles", 64'(busy_cnt), 64'd33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        @(negedge clk);
        check("reset_outputs", {26'd0, ready, outValid, result, zero, aluctrl, err, busy},
              {26'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'b0000, 1'b0, 1'b0});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_outvalid", {63'd0, outValid}, 64'd0);

        // Single-cycle ops, back-to-back.
        issue(2'b10, 6'h20, 32'd5, 32'd7, 1'b1, 32'd12, 4'b0010, 1'b0);
        issue(2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd1, 4'b0111, 1'b0);
        issue(2'b10, 6'h27, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 4'b1100, 1'b0);
        issue(2'b01, 6'h00, 32'd3, 32'd3, 1'b1, 32'd0, 4'b0110, 1'b0);
        issue(2'b10, 6'h24, 32'h0000F0F0, 32'h0000FF00, 1'b1, 32'h0000F000, 4'b0000, 1'b0);
        issue(2'b10, 6'h25, 32'h0000000F, 32'h000000F0, 1'b1, 32'h000000FF, 4'b0001, 1'b0);
        issue(2'b00, 6'h3F, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 4'b0010, 1'b0);
        issue(2'b10, 6'h22, 32'd2, 32'd5, 1'b1, 32'hFFFFFFFD, 4'b0110, 1'b0);
        issue(2'b10, 6'h2A, 32'd1, 32'hFFFFFFFF, 1'b1, 32'd0, 4'b0111, 1'b0);
        // Invalid ops.
        issue(2'b10, 6'h3F, 32'd9, 32'd9, 1'b1, 32'd0, 4'b1111, 1'b1);
        issue(2'b11, 6'h20, 32'd9, 32'd9, 1'b1, 32'd0, 4'b1111, 1'b1);
        idle();
        @(negedge clk);

        // Signed multiply, then read HI/LO back.
        run_mult(6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 4'b1000);
        issue(2'b10, 6'h10, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 4'b1010, 1'b0);
        issue(2'b10, 6'h12, 32'd0, 32'd0, 1'b1, 32'hFFFFFFEB, 4'b1011, 1'b0);
        idle();

        // Unsigned multiply.
        run_mult(6'h19, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4'b1001);
        issue(2'b10, 6'h10, 32'd0, 32'd0, 1'b1, 32'h00000001, 4'b1010, 1'b0);
        issue(2'b10, 6'h12, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFE, 4'b1011, 1'b0);
        idle();

        // Abort a multiply with reset.
        issue(2'b10, 6'h18, 32'h00001234, 32'd5, 1'b0, 32'd0, 4'b0000, 1'b0);
        idle();
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {27'd0, ready, outValid, result, zero, busy},
              {27'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_outvalid", {63'd0, outValid}, 64'd0);
        check("abort_ready", {63'd0, ready}, 64'd1);
        issue(2'b10, 6'h10, 32'd0, 32'd0, 1'b1, 32'd0, 4'b1010, 1'b0);
        issue(2'b10, 6'h12, 32'd0, 32'd0, 1'b1, 32'd0, 4'b1011, 1'b0);
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
